// File: rtl/addsub_rr_arbiter_if.sv
// Bundle of requester, shared adder/subtractor and response signals for addsub_rr_arbiter.
// The slave modport is the arbiter's view, and the master modport is the environment's view.
interface addsub_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_sub;
    logic [WIDTH-1:0]         alu_a;
    logic [WIDTH-1:0]         alu_b;
    logic                     alu_en;
    logic [WIDTH-1:0]         alu_sum;
    logic                     alu_cbout;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_cbout;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, alu_sum, alu_cbout, rsp_ready,
        output req_ready, alu_a, alu_b, alu_en, rsp_valid, rsp_id, rsp_sum, rsp_cbout
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, alu_sum, alu_cbout, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_en, rsp_valid, rsp_id, rsp_sum, rsp_cbout
    );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter that shares one adder_cum_subtractor, with one operation in flight at a time.
// Define ADDSUB_ARB_STATS_EN to add the saturating op_count and sub_count outputs.
module addsub_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    addsub_rr_arbiter_if.slave  bus,
    output logic [1:0]          o_dbg_state
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [15:0]         op_count,
    output logic [15:0]         sub_count
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_rr_next;
    logic                w_found;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic [WIDTH-1:0]    r_alu_a;
    logic [WIDTH-1:0]    r_alu_b;
    logic                r_alu_en;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [WIDTH-1:0]    r_rsp_sum;
    logic                r_rsp_cbout;
    logic                w_rsp_fire;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_valid may drop before it is granted. rsp_* stay frozen while rsp_valid is high and rsp_ready is low.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(idx);
            end
        end
    end

    assign w_rr_next  = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    assign w_rsp_fire = (r_state == ST_RESP) && r_rsp_valid && bus.rsp_ready;

    always_comb begin
        w_req_ready = '0;
        if (rst_n && (r_state == ST_IDLE) && w_found) w_req_ready[w_winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_found) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_RESP;
            ST_RESP:  if (w_rsp_fire) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Operands are held after issue so the shared unit does not toggle while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cbout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_alu_a  <= bus.req_a[int'(w_winner)*WIDTH +: WIDTH];
                        r_alu_b  <= bus.req_b[int'(w_winner)*WIDTH +: WIDTH];
                        r_alu_en <= bus.req_sub[w_winner];
                        r_rsp_id <= w_winner;
                        r_rr_ptr <= w_rr_next;
                    end
                end
                ST_ISSUE: begin
                    r_rsp_sum   <= bus.alu_sum;
                    r_rsp_cbout <= bus.alu_cbout;
                    r_rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (w_rsp_fire) r_rsp_valid <= 1'b0;
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

`ifdef ADDSUB_ARB_STATS_EN
    logic [15:0] r_op_count;
    logic [15:0] r_sub_count;

    // r_alu_en still holds the completing op's mode, because it only reloads on the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count  <= '0;
            r_sub_count <= '0;
        end else if (w_rsp_fire) begin
            if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
            if (r_alu_en && (r_sub_count != 16'hFFFF)) r_sub_count <= r_sub_count + 16'd1;
        end
    end

    assign op_count  = r_op_count;
    assign sub_count = r_sub_count;
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_en    = r_alu_en;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_cbout = r_rsp_cbout;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed bench for addsub_rr_arbiter with a behavioural 4-bit adder_cum_subtractor attached.
// Define ADDSUB_ARB_STATS_EN to also check the statistics counters.
module tb_addsub_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int ID_W    = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
`ifdef ADDSUB_ARB_STATS_EN
    logic [15:0] op_count;
    logic [15:0] sub_count;
`endif

    int total = 0;
    int bad   = 0;

    addsub_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

    addsub_rr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
`ifdef ADDSUB_ARB_STATS_EN
        ,
        .op_count    (op_count),
        .sub_count   (sub_count)
`endif
    );

    // Shared unit: add gives a carry out; subtract gives a borrow out (set when A < B).
    logic [WIDTH:0] alu_wide;
    assign alu_wide      = bus.alu_en ? ({1'b0, bus.alu_a} - {1'b0, bus.alu_b})
                                      : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});
    assign bus.alu_sum   = alu_wide[WIDTH-1:0];
    assign bus.alu_cbout = alu_wide[WIDTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] exp_sum;
        logic       exp_c;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b, input logic sub);
        bus.req_a[idx*WIDTH +: WIDTH] = a;
        bus.req_b[idx*WIDTH +: WIDTH] = b;
        bus.req_sub[idx]              = sub;
    endtask

    // Call this #1 after a rising edge while the DUT is idle and rsp_ready is high.
    task automatic do_op(input vec_t v);
        set_req(v.idx, v.a, v.b, v.sub);
        bus.req_valid = 4'(1 << v.idx);
        #1;
        chk("grant", 32'(bus.req_ready), 32'(1 << v.idx));
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("issue_state", 32'(dbg_state), 32'd1);
        chk("issue_alu_a", 32'(bus.alu_a), 32'(v.a));
        chk("issue_alu_b", 32'(bus.alu_b), 32'(v.b));
        chk("issue_alu_en", 32'(bus.alu_en), 32'(v.sub));
        chk("issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(v.idx));
        chk("rsp_sum", 32'(bus.rsp_sum), 32'(v.exp_sum));
        chk("rsp_cbout", 32'(bus.rsp_cbout), 32'(v.exp_c));
        @(posedge clk); #1;
        chk("rsp_done", 32'(bus.rsp_valid), 32'd0);
        chk("idle_state", 32'(dbg_state), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 4'b0100, 4'b0111, 1'b0, 4'b1011, 1'b0};
        vecs[1] = '{2, 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b0};
        vecs[2] = '{1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1};
        vecs[3] = '{3, 4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b1};
        vecs[4] = '{1, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1};

        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        chk("rst_rsp_cbout", 32'(bus.rsp_cbout), 32'd0);
        chk("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_en}), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        bus.req_valid = '0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: T1, T2 and single-requester boundary values (wrap, borrow, carry).
        for (int i = 0; i < 5; i++) do_op(vecs[i]);
`ifdef ADDSUB_ARB_STATS_EN
        chk("op_count", 32'(op_count), 32'd5);
        chk("sub_count", 32'(sub_count), 32'd2);
`endif

        // T4: back-pressure and operands changing after accept.
        bus.rsp_ready = 1'b0;
        set_req(1, 4'd6, 4'd2, 1'b0);
        bus.req_valid = 4'b0010;
        @(posedge clk); #1;
        bus.req_a[1*WIDTH +: WIDTH] = 4'hF;
        bus.req_valid = 4'b0100;
        @(posedge clk); #1;
        chk("stall_first_sum", 32'(bus.rsp_sum), 32'd8);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_id", 32'(bus.rsp_id), 32'd1);
            chk("stall_sum", 32'(bus.rsp_sum), 32'd8);
            chk("stall_cbout", 32'(bus.rsp_cbout), 32'd0);
            chk("stall_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_alu_a", 32'(bus.alu_a), 32'd6);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        chk("stall_release", 32'(bus.rsp_valid), 32'd0);
        chk("stall_idle", 32'(dbg_state), 32'd0);

        // T5: reset asserted while a response is pending.
        bus.rsp_ready = 1'b0;
        set_req(0, 4'd1, 4'd2, 1'b0);
        bus.req_valid = 4'b0001;
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        chk("t5_pending", 32'(bus.rsp_valid), 32'd1);
        set_req(3, 4'd7, 4'd1, 1'b1);
        bus.req_valid = 4'b1000;
        rst_n = 1'b0;
        #1;
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t5_rsp_fields", 32'({bus.rsp_id, bus.rsp_sum, bus.rsp_cbout}), 32'd0);
        chk("t5_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_en}), 32'd0);
        chk("t5_req_ready", 32'(bus.req_ready), 32'd0);
        chk("t5_state", 32'(dbg_state), 32'd0);
`ifdef ADDSUB_ARB_STATS_EN
        chk("t5_op_count", 32'(op_count), 32'd0);
`endif
        @(posedge clk); #3;
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        chk("t5_grant3", 32'(bus.req_ready), 32'b1000);
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("t5_alu_en", 32'(bus.alu_en), 32'd1);
        @(posedge clk); #1;
        chk("t5_rsp_id", 32'(bus.rsp_id), 32'd3);
        chk("t5_rsp_sum", 32'(bus.rsp_sum), 32'd6);
        chk("t5_rsp_cbout", 32'(bus.rsp_cbout), 32'd0);
        @(posedge clk); #1;

        // A request withdrawn before the edge must not be issued.
        bus.req_valid = 4'b0010;
        #1;
        chk("drop_ready", 32'(bus.req_ready), 32'b0010);
        #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        chk("drop_state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        chk("drop_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // T3: every requester valid, starting from rr_ptr=0.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'(i + 1), 4'(i), 1'b0);
        bus.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % NUM_REQ;
            #1;
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << e));
            chk("rr_onehot", 32'($countones(bus.req_ready)), 32'd1);
            @(posedge clk); #1;
            chk("rr_issue_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            chk("rr_rsp_id", 32'(bus.rsp_id), 32'(e));
            chk("rr_rsp_sum", 32'(bus.rsp_sum), 32'(2 * e + 1));
            @(posedge clk); #1;
            chk("rr_idle", 32'(dbg_state), 32'd0);
        end
        bus.req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
